// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped IO controller: IO space tag,
// register offsets, UART control bit positions and access classification.
package mmio_pkg;

  localparam logic [1:0] IO_TAG_DEFAULT = 2'b10;

  localparam logic [7:0] OFF_UART_CTRL    = 8'h00;
  localparam logic [7:0] OFF_UART_RX_DATA = 8'h04;
  localparam logic [7:0] OFF_UART_TX_DATA = 8'h08;
  localparam logic [7:0] OFF_CYCLE_CNT    = 8'h10;
  localparam logic [7:0] OFF_INSTR_CNT    = 8'h14;
  localparam logic [7:0] OFF_CNT_CLEAR    = 8'h18;
  localparam logic [7:0] OFF_BR_SEEN_CNT  = 8'h1C;
  localparam logic [7:0] OFF_BR_TAKEN_CNT = 8'h20;

  localparam int UART_CTRL_TX_READY_BIT = 0;
  localparam int UART_CTRL_RX_VALID_BIT = 1;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_LOAD,
    ACC_STORE
  } acc_kind_t;

  // A simultaneous load and store is treated as a store only.
  function automatic acc_kind_t access_kind(input logic rd_en, input logic wr_en);
    if (wr_en)
      return ACC_STORE;
    else if (rd_en)
      return ACC_LOAD;
    else
      return ACC_IDLE;
  endfunction

endpackage

// File: rtl/mmio_ctrl_if.sv
// CPU load/store bus seen by the IO controller; the CPU side is the master.
interface mmio_bus_if #(
  parameter int DWIDTH = 32
);
  logic [DWIDTH-1:0] addr;
  logic              rd_en;
  logic              wr_en;
  logic [DWIDTH-1:0] wr_data;
  logic              stall;
  logic [DWIDTH-1:0] rd_data;
  logic              io_hit;

  modport master (
    output addr, rd_en, wr_en, wr_data, stall,
    input  rd_data, io_hit
  );

  modport slave (
    input  addr, rd_en, wr_en, wr_data, stall,
    output rd_data, io_hit
  );
endinterface

// File: rtl/mmio_counter.sv
// Wrapping up-counter with synchronous reset and a clear that beats increment.
module mmio_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      count <= '0;
    else if (inc)
      count <= count + CNT_WIDTH'(1);
  end

endmodule

// File: rtl/mmio_ctrl.sv
// Memory-mapped IO controller: UART registers plus cycle/instruction counters.
// Optional branch counters at 0x1C/0x20 are built when MMIO_BRANCH_CNT_EN is defined.
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int         DWIDTH    = 32,
  parameter int         CNT_WIDTH = 32,
  parameter logic [1:0] IO_TAG    = IO_TAG_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  mmio_bus_if.slave    bus,
  input  logic         instr_retire,
  input  logic         uart_rx_valid,
  input  logic [7:0]   uart_rx_out,
  input  logic         uart_tx_ready,
  output logic         rx_data_out_ready,
  output logic         tx_data_in_valid,
  output logic [7:0]   tx_data_in
`ifdef MMIO_BRANCH_CNT_EN
  ,
  input  logic         branch_valid,
  input  logic         branch_taken
`endif
);

  acc_kind_t         kind;
  logic [7:0]        offset;
  logic              is_io;
  logic              active;
  logic              io_load;
  logic              io_store;
  logic              cnt_clr;
  logic              instr_inc;
  logic [DWIDTH-1:0] rd_next;
  logic [DWIDTH-1:0] rd_data_q;
  logic              io_hit_q;
  logic              unused_bits;

  logic [CNT_WIDTH-1:0] cycle_count;
  logic [CNT_WIDTH-1:0] instr_count;

  assign kind     = access_kind(bus.rd_en, bus.wr_en);
  assign offset   = bus.addr[7:0];
  assign is_io    = (bus.addr[DWIDTH-1 -: 2] == IO_TAG);
  assign active   = !rst && !bus.stall;
  assign io_load  = active && is_io && (kind == ACC_LOAD);
  assign io_store = active && is_io && (kind == ACC_STORE);

  assign cnt_clr   = io_store && (offset == OFF_CNT_CLEAR);
  assign instr_inc = instr_retire && !bus.stall;

  assign unused_bits = ^{bus.addr[DWIDTH-3:8], bus.wr_data[DWIDTH-1:8]};

  mmio_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (1'b1),
    .count (cycle_count)
  );

  mmio_counter #(.CNT_WIDTH(CNT_WIDTH)) u_instr_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (instr_inc),
    .count (instr_count)
  );

`ifdef MMIO_BRANCH_CNT_EN
  logic [CNT_WIDTH-1:0] br_seen_count;
  logic [CNT_WIDTH-1:0] br_taken_count;

  mmio_counter #(.CNT_WIDTH(CNT_WIDTH)) u_br_seen_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (branch_valid && !bus.stall),
    .count (br_seen_count)
  );

  mmio_counter #(.CNT_WIDTH(CNT_WIDTH)) u_br_taken_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (branch_valid && branch_taken && !bus.stall),
    .count (br_taken_count)
  );
`endif

  // Counter values are zero-extended; unmapped offsets read as zero.
  always_comb begin
    rd_next = '0;
    case (offset)
      OFF_UART_CTRL: begin
        rd_next[UART_CTRL_RX_VALID_BIT] = uart_rx_valid;
        rd_next[UART_CTRL_TX_READY_BIT] = uart_tx_ready;
      end
      OFF_UART_RX_DATA: rd_next[7:0]           = uart_rx_out;
      OFF_CYCLE_CNT:    rd_next[CNT_WIDTH-1:0] = cycle_count;
      OFF_INSTR_CNT:    rd_next[CNT_WIDTH-1:0] = instr_count;
`ifdef MMIO_BRANCH_CNT_EN
      OFF_BR_SEEN_CNT:  rd_next[CNT_WIDTH-1:0] = br_seen_count;
      OFF_BR_TAKEN_CNT: rd_next[CNT_WIDTH-1:0] = br_taken_count;
`endif
      default:          rd_next = '0;
    endcase
  end

  assign rx_data_out_ready = io_load && (offset == OFF_UART_RX_DATA) && uart_rx_valid;

  // A stall freezes the load result; tx_data_in keeps the last byte sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q        <= '0;
      io_hit_q         <= 1'b0;
      tx_data_in_valid <= 1'b0;
      tx_data_in       <= '0;
    end else begin
      tx_data_in_valid <= 1'b0;
      if (!bus.stall) begin
        io_hit_q <= io_load;
        if (io_load)
          rd_data_q <= rd_next;
      end
      if (io_store && (offset == OFF_UART_TX_DATA) && uart_tx_ready) begin
        tx_data_in_valid <= 1'b1;
        tx_data_in       <= bus.wr_data[7:0];
      end
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.io_hit  = io_hit_q;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Self-checking bench for mmio_ctrl: directed scenarios followed by random
// traffic, all compared against a behavioural model of the register map.
`timescale 1ns/1ps
module tb_mmio_ctrl;

  localparam int DW      = 32;
  localparam int CW      = 8;
  localparam int CNT_MOD = 1 << CW;

  typedef struct {
    logic        rst;
    logic [31:0] addr;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        stall;
    logic        retire;
    logic        rx_valid;
    logic [7:0]  rx_out;
    logic        tx_ready;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_retire;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_out;
  logic       uart_tx_ready;
  logic       rx_data_out_ready;
  logic       tx_data_in_valid;
  logic [7:0] tx_data_in;

  mmio_bus_if #(.DWIDTH(DW)) bus ();

  mmio_ctrl #(.DWIDTH(DW), .CNT_WIDTH(CW), .IO_TAG(2'b10)) dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus),
    .instr_retire      (instr_retire),
    .uart_rx_valid     (uart_rx_valid),
    .uart_rx_out       (uart_rx_out),
    .uart_tx_ready     (uart_tx_ready),
    .rx_data_out_ready (rx_data_out_ready),
    .tx_data_in_valid  (tx_data_in_valid),
    .tx_data_in        (tx_data_in)
`ifdef MMIO_BRANCH_CNT_EN
    ,
    .branch_valid      (1'b0),
    .branch_taken      (1'b0)
`endif
  );

  always #5 clk = ~clk;

  stim_t       cur;
  int          cyc_cnt;
  int          ins_cnt;
  logic [31:0] exp_rd;
  logic        exp_hit;
  logic        exp_txv;
  logic [7:0]  exp_txd;
  logic        exp_rx;
  logic        chk_en = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Pin both the DUT and the model against a hand-computed value.
  task automatic pin(input string name, input logic [31:0] dut_val, input logic [31:0] model_val,
                     input logic [31:0] lit);
    compare({name, "_dut"}, dut_val, lit);
    compare({name, "_model"}, model_val, lit);
  endtask

  function automatic stim_t idleS();
    stim_t s;
    s.rst = 1'b0; s.addr = 32'h0; s.rd_en = 1'b0; s.wr_en = 1'b0; s.wr_data = 32'h0;
    s.stall = 1'b0; s.retire = 1'b0; s.rx_valid = 1'b0; s.rx_out = 8'h0; s.tx_ready = 1'b0;
    return s;
  endfunction

  function automatic stim_t mkLoad(input logic [31:0] a);
    stim_t s = idleS();
    s.addr = a; s.rd_en = 1'b1;
    return s;
  endfunction

  function automatic stim_t mkStore(input logic [31:0] a, input logic [31:0] d);
    stim_t s = idleS();
    s.addr = a; s.wr_en = 1'b1; s.wr_data = d;
    return s;
  endfunction

  function automatic logic isIo(input stim_t s);
    return s.addr[31:30] == 2'b10;
  endfunction

  function automatic logic [31:0] readValue(input stim_t s);
    case (s.addr[7:0])
      8'h00:   return {30'd0, s.rx_valid, s.tx_ready};
      8'h04:   return {24'd0, s.rx_out};
      8'h10:   return 32'(cyc_cnt);
      8'h14:   return 32'(ins_cnt);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic rxExpect(input stim_t s);
    return !s.rst && !s.stall && s.rd_en && !s.wr_en && isIo(s) && s.addr[7:0] == 8'h04 && s.rx_valid;
  endfunction

  // Model of one clock edge acting on the inputs currently held on the pins.
  task automatic modelAdvance();
    int nc;
    int ni;
    logic io;
    logic [7:0] off;
    if (cur.rst) begin
      cyc_cnt = 0; ins_cnt = 0; exp_rd = '0; exp_hit = 1'b0; exp_txv = 1'b0; exp_txd = '0;
      return;
    end
    io  = isIo(cur);
    off = cur.addr[7:0];
    nc  = (cyc_cnt + 1) % CNT_MOD;
    ni  = (cur.retire && !cur.stall) ? (ins_cnt + 1) % CNT_MOD : ins_cnt;
    exp_txv = 1'b0;
    if (!cur.stall) begin
      if (cur.wr_en) begin
        if (io && off == 8'h08 && cur.tx_ready) begin
          exp_txv = 1'b1;
          exp_txd = cur.wr_data[7:0];
        end
        if (io && off == 8'h18) begin
          nc = 0;
          ni = 0;
        end
        exp_hit = 1'b0;
      end else if (cur.rd_en) begin
        exp_hit = io;
        if (io) exp_rd = readValue(cur);
      end else begin
        exp_hit = 1'b0;
      end
    end
    cyc_cnt = nc;
    ins_cnt = ni;
  endtask

  task automatic drivePins(input stim_t s);
    cur           = s;
    rst           = s.rst;
    bus.addr      = s.addr;
    bus.rd_en     = s.rd_en;
    bus.wr_en     = s.wr_en;
    bus.wr_data   = s.wr_data;
    bus.stall     = s.stall;
    instr_retire  = s.retire;
    uart_rx_valid = s.rx_valid;
    uart_rx_out   = s.rx_out;
    uart_tx_ready = s.tx_ready;
  endtask

  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #2;
    modelAdvance();
    chk_en = 1'b1;
    drivePins(s);
    exp_rx = rxExpect(s);
  endtask

  task automatic checkOutput();
    compare("rd_data", bus.rd_data, exp_rd);
    compare("io_hit", {31'd0, bus.io_hit}, {31'd0, exp_hit});
    compare("tx_valid", {31'd0, tx_data_in_valid}, {31'd0, exp_txv});
    compare("tx_data", {24'd0, tx_data_in}, {24'd0, exp_txd});
    compare("rx_ready", {31'd0, rx_data_out_ready}, {31'd0, exp_rx});
  endtask

  always @(negedge clk) begin
    if (chk_en) checkOutput();
  end

  task automatic doReset(input int n);
    stim_t s = idleS();
    s.rst = 1'b1;
    for (int i = 0; i < n; i++) applyStimulus(s);
  endtask

  function automatic stim_t randS();
    stim_t s = idleS();
    logic [1:0] tag;
    logic [7:0] off;
    int t = $urandom_range(0, 9);
    tag = (t == 0) ? 2'b00 : (t == 1) ? 2'b11 : 2'b10;
    case ($urandom_range(0, 10))
      0: off = 8'h00;  1: off = 8'h04;  2: off = 8'h08;  3: off = 8'h0C;
      4: off = 8'h10;  5: off = 8'h14;  6: off = 8'h18;  7: off = 8'h1C;
      8: off = 8'h20;  9: off = 8'h24;  default: off = 8'($urandom);
    endcase
    s.rst      = ($urandom_range(0, 99) < 2);
    s.addr     = {tag, 22'($urandom), off};
    s.rd_en    = ($urandom_range(0, 99) < 45);
    s.wr_en    = ($urandom_range(0, 99) < 30);
    if (off == 8'h18 && $urandom_range(0, 3) != 0) s.wr_en = 1'b0;
    s.wr_data  = $urandom;
    s.stall    = ($urandom_range(0, 99) < 25);
    s.retire   = ($urandom_range(0, 99) < 60);
    s.rx_valid = ($urandom_range(0, 1) == 1);
    s.rx_out   = 8'($urandom);
    s.tx_ready = ($urandom_range(0, 1) == 1);
    return s;
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    int    c0;
    s = idleS();
    s.rst = 1'b1;
    drivePins(s);
    cyc_cnt = 0; ins_cnt = 0; exp_rd = '0; exp_hit = 1'b0;
    exp_txv = 1'b0; exp_txd = '0; exp_rx = 1'b0;

    // Power-up value plus two calls gives three reset edges.
    doReset(2);
    repeat (10) applyStimulus(idleS());
    applyStimulus(mkLoad(32'h8000_0010));
    applyStimulus(mkLoad(32'h8000_0014));
    #1;
    pin("cycle_after_reset", bus.rd_data, exp_rd, 32'd10);
    compare("cycle_io_hit", {31'd0, bus.io_hit}, 32'd1);
    applyStimulus(idleS());
    #1;
    pin("instr_after_reset", bus.rd_data, exp_rd, 32'd0);

    s = mkLoad(32'h8000_0004); s.rx_valid = 1'b1; s.rx_out = 8'h5A;
    applyStimulus(s);
    #1;
    pin("rx_pulse", {31'd0, rx_data_out_ready}, {31'd0, exp_rx}, 32'd1);
    s = idleS(); s.rx_valid = 1'b1; s.rx_out = 8'h5A;
    applyStimulus(s);
    #1;
    compare("rx_pulse_once", {31'd0, rx_data_out_ready}, 32'd0);
    pin("rx_read", bus.rd_data, exp_rd, 32'h0000_005A);

    c0 = cyc_cnt;
    s = mkLoad(32'h8000_0004); s.rx_valid = 1'b1; s.rx_out = 8'h33; s.stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(s);
      #1;
      compare("stall_no_rx_pulse", {31'd0, rx_data_out_ready}, 32'd0);
      compare("stall_rd_hold", bus.rd_data, 32'h0000_005A);
    end
    compare("stall_cycle_delta", 32'((cyc_cnt - c0 + CNT_MOD) % CNT_MOD), 32'd4);
    s.stall = 1'b0;
    applyStimulus(s);
    #1;
    compare("unstall_rx_pulse", {31'd0, rx_data_out_ready}, 32'd1);
    applyStimulus(mkLoad(32'h8000_0010));
    #1;
    pin("unstall_rx_read", bus.rd_data, exp_rd, 32'h0000_0033);
    applyStimulus(idleS());

    s = mkStore(32'h8000_0008, 32'h0000_0041); s.tx_ready = 1'b1;
    applyStimulus(s);
    applyStimulus(idleS());
    #1;
    pin("tx_valid", {31'd0, tx_data_in_valid}, {31'd0, exp_txv}, 32'd1);
    pin("tx_data", {24'd0, tx_data_in}, {24'd0, exp_txd}, 32'h41);
    applyStimulus(idleS());
    #1;
    compare("tx_single_pulse", {31'd0, tx_data_in_valid}, 32'd0);
    s = mkStore(32'h8000_0008, 32'h0000_0077); s.tx_ready = 1'b0;
    applyStimulus(s);
    applyStimulus(idleS());
    #1;
    compare("tx_drop_valid", {31'd0, tx_data_in_valid}, 32'd0);
    compare("tx_drop_data", {24'd0, tx_data_in}, 32'h41);

    s = mkStore(32'h8000_0008, 32'h0000_0099); s.rd_en = 1'b1; s.tx_ready = 1'b1;
    applyStimulus(s);
    applyStimulus(idleS());
    #1;
    compare("both_en_tx_valid", {31'd0, tx_data_in_valid}, 32'd1);
    compare("both_en_io_hit", {31'd0, bus.io_hit}, 32'd0);

    applyStimulus(mkLoad(32'h8000_000C));
    applyStimulus(mkStore(32'h8000_0010, 32'h0000_00AB));
    #1;
    compare("unmapped_read", bus.rd_data, 32'd0);
    applyStimulus(mkLoad(32'h8000_0020));
    applyStimulus(mkLoad(32'h4000_0004));
    #1;
    compare("unmapped_read_20", bus.rd_data, 32'd0);
    applyStimulus(idleS());
    #1;
    compare("non_io_hit", {31'd0, bus.io_hit}, 32'd0);

    s = mkStore(32'h8000_0008, 32'h0000_0055); s.tx_ready = 1'b1; s.rst = 1'b1;
    applyStimulus(s);
    s = mkLoad(32'h8000_0004); s.rx_valid = 1'b1; s.rst = 1'b1;
    applyStimulus(s);
    #1;
    compare("reset_no_rx_pulse", {31'd0, rx_data_out_ready}, 32'd0);
    compare("reset_no_tx_pulse", {31'd0, tx_data_in_valid}, 32'd0);
    applyStimulus(idleS());
    #1;
    compare("after_reset_no_tx", {31'd0, tx_data_in_valid}, 32'd0);
    compare("after_reset_tx_data", {24'd0, tx_data_in}, 32'd0);

    s = mkStore(32'h8000_0018, 32'hDEAD_BEEF); s.retire = 1'b1;
    applyStimulus(s);
    applyStimulus(mkLoad(32'h8000_0014));
    applyStimulus(idleS());
    #1;
    pin("clear_beats_inc", bus.rd_data, exp_rd, 32'd0);
    repeat (253) applyStimulus(idleS());
    applyStimulus(mkLoad(32'h8000_0010));
    applyStimulus(mkLoad(32'h8000_0010));
    #1;
    pin("cycle_max", bus.rd_data, exp_rd, 32'h0000_00FF);
    applyStimulus(idleS());
    #1;
    pin("cycle_wrap", bus.rd_data, exp_rd, 32'd0);

    for (int i = 0; i < 800; i++) applyStimulus(randS());
    applyStimulus(idleS());
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mmio_ctrl.md
MMIO_CTRL -- requirements
Module: mmio_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, meaning CPU data and address width.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, meaning counter width; CNT_WIDTH <= DWIDTH.
REQ-003 SHALL have parameter IO_TAG, default 2'b10, meaning addr[DWIDTH-1:DWIDTH-2] value selecting IO space.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 addr  in  DWIDTH  ALU byte address of current load/store.
REQ-007 rd_en  in  1  load in flight; wr_en  in  1  store in flight.
REQ-008 wr_data  in  DWIDTH  store data.
REQ-009 stall  in  1  pipeline stall; holds rd_data and suppresses side effects.
REQ-010 instr_retire  in  1  one instruction committed this cycle.
REQ-011 uart_rx_valid  in  1; uart_rx_out  in  8; uart_tx_ready  in  1.
REQ-012 rx_data_out_ready  out  1; tx_data_in_valid  out  1; tx_data_in  out  8.
REQ-013 rd_data  out  DWIDTH  registered IO read data; io_hit  out  1  registered "last load was IO".

Function
REQ-014 SHALL decode IO access when addr top two bits == IO_TAG; offsets in addr[7:0]: 0x00 UART ctrl, 0x04 UART rx data, 0x08 UART tx data, 0x10 cycle count, 0x14 instr count, 0x18 counter clear.
REQ-015 SHALL return read data one cycle after rd_en (load latency 1), registered into rd_data, io_hit set for that cycle.
REQ-016 UART ctrl read SHALL return {zeros, uart_rx_valid, uart_tx_ready} sampled in the rd_en cycle.
REQ-017 rx data read SHALL return {zeros, uart_rx_out}; rx_data_out_ready SHALL pulse exactly one cycle, combinationally in the rd_en cycle, only if uart_rx_valid and not stall.
REQ-018 Store to 0x08 with uart_tx_ready SHALL assert tx_data_in_valid one cycle with tx_data_in = wr_data[7:0]; with tx not ready the store SHALL be dropped, no pulse.
REQ-019 Cycle counter SHALL increment every non-reset cycle, including stalls.
REQ-020 Instr counter SHALL increment in cycles with instr_retire high and stall low.
REQ-021 Counters SHALL wrap from 2^CNT_WIDTH-1 to 0; reads zero-extend to DWIDTH.
REQ-022 Store (any data) to 0x18 SHALL zero both counters next edge; clear beats simultaneous increment (value 0, not 1).
REQ-023 Reads of unmapped IO offsets and writes to read-only offsets SHALL return 0 / have no effect.
REQ-024 With stall high, rd_data, io_hit SHALL hold; no pulse outputs, no counter clear.
REQ-025 rd_en and wr_en both high SHALL be treated as store only.

Reset
REQ-026 During rst: counters 0, rd_data 0, io_hit 0, all pulse outputs 0, tx_data_in 0.
REQ-027 rst mid-transfer SHALL abort it; no pulse SHALL be issued in the reset cycle or the cycle after.

Configuration
REQ-028 MMIO_BRANCH_CNT_EN defined: adds branch_valid and branch_taken inputs (1 bit each), counters at 0x1C (branches seen) and 0x20 (taken), same width, wrap and clear rules.
REQ-029 MMIO_BRANCH_CNT_EN undefined: ports absent, 0x1C/0x20 read 0.

Structure
REQ-030 Package mmio_pkg SHALL hold offset constants, IO_TAG default, UART ctrl bit positions.
REQ-031 Sub-module mmio_counter (params CNT_WIDTH; ports clk, rst, clr, inc, count) SHALL implement each counter.

Verification
REQ-032 rst 3 cycles then 10 idle cycles -> cycle count read = 10 (+ read-cycle offset fixed in bench), instr count 0.
REQ-033 uart_rx_valid=1, uart_rx_out=0x5A, load 0x80000004 -> rx_data_out_ready 1 cycle, next cycle rd_data=0x0000005A.
REQ-034 store 0x41 to 0x80000008, tx_ready=1 -> tx_data_in_valid 1 cycle, tx_data_in=0x41; tx_ready=0 -> no pulse.
REQ-035 force counter to 0xFFFFFFFF, one cycle -> 0; store to 0x18 while instr_retire=1 -> instr count 0.
REQ-036 stall held 4 cycles during rx-data load -> no rx pulse, rd_data unchanged, cycle count +4.
